// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the kakacpu core.
// Optional illegal-instruction trap path enabled by defining KAKACPU_ILLEGAL_TRAP_EN.
package instr_type;
  typedef enum logic [3:0] {
    lui, auipc, jal, jalr, branch_type, load_type, store_type,
    imm_arith_type, reg_arith_type, fence_type, system_type
  } opcode_t;
endpackage

module core_sequencer (
  input  logic                clk,
  input  logic                rst,
  input  instr_type::opcode_t opcode_type,
  input  logic                illegal,
  input  logic                branch_taken,
  output logic                imem_req,
  input  logic                imem_ready,
  output logic                ir_we,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  output logic                regfile_we,
  output logic                csr_en,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                trap,
  output logic                retire,
  output logic [2:0]          state
);
  import instr_type::*;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  state_t  state_q;
  opcode_t class_q;
  logic    illegal_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:     if (imem_ready) state_q <= DECODE;
        DECODE: begin
`ifdef KAKACPU_ILLEGAL_TRAP_EN
          state_q <= illegal ? TRAP : EXECUTE;
`else
          state_q <= EXECUTE;
`endif
        end
        EXECUTE: begin
          if (illegal_q) begin
            state_q <= FETCH;
          end else begin
            case (class_q)
              load_type, store_type: state_q <= MEMORY;
              lui, auipc, jal, jalr, imm_arith_type, reg_arith_type, system_type:
                state_q <= WRITEBACK;
              default:               state_q <= FETCH;
            endcase
          end
        end
        MEMORY:    if (dmem_ready) state_q <= (class_q == load_type) ? WRITEBACK : FETCH;
        default:   state_q <= FETCH;
      endcase
    end
  end

  // Instruction class is captured once in DECODE; later states use only the latched copy.
  always_ff @(posedge clk) begin
    if (state_q == DECODE) begin
      class_q   <= opcode_type;
      illegal_q <= illegal;
    end
  end

  assign state = rst ? 3'd0 : state_q;

  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regfile_we = 1'b0;
    csr_en     = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'd0;
    trap       = 1'b0;
    retire     = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        EXECUTE: begin
          // Illegal (when not trapping), fence and unknown classes retire as no-ops.
          if (illegal_q) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            case (class_q)
              branch_type: begin
                pc_we  = 1'b1;
                pc_sel = branch_taken ? 2'd1 : 2'd0;
                retire = 1'b1;
              end
              load_type, store_type, lui, auipc, jal, jalr,
              imm_arith_type, reg_arith_type, system_type: ;
              default: begin
                pc_we  = 1'b1;
                retire = 1'b1;
              end
            endcase
          end
        end
        MEMORY: begin
          dmem_req = 1'b1;
          dmem_we  = (class_q == store_type);
          if (dmem_ready && class_q == store_type) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        WRITEBACK: begin
          regfile_we = 1'b1;
          pc_we      = 1'b1;
          retire     = 1'b1;
          csr_en     = (class_q == system_type);
          if (class_q == jal)       pc_sel = 2'd1;
          else if (class_q == jalr) pc_sel = 2'd2;
        end
`ifdef KAKACPU_ILLEGAL_TRAP_EN
        TRAP: begin
          trap   = 1'b1;
          pc_we  = 1'b1;
          pc_sel = 2'd3;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed per-cycle expectations queued by
// the driver and checked by an independent negedge monitor.
module tb_core_sequencer;
  import instr_type::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  opcode_t    op = reg_arith_type;
  logic       illegal = 1'b0, branch_taken = 1'b0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, ir_we, dmem_req, dmem_we, regfile_we, csr_en, pc_we, trap, retire;
  logic [1:0] pc_sel;
  logic [2:0] state;

  core_sequencer dut (
    .clk(clk), .rst(rst), .opcode_type(op), .illegal(illegal), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .regfile_we(regfile_we), .csr_en(csr_en), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap), .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Vector order: state, imem_req, ir_we, dmem_req, dmem_we, regfile_we, csr_en, pc_we, pc_sel, trap, retire
  function automatic logic [13:0] E(input logic [2:0] st, input logic imr, irw, dr, dw, rfw, csr, pcw,
                                    input logic [1:0] pcs, input logic trp, ret);
    return {st, imr, irw, dr, dw, rfw, csr, pcw, pcs, trp, ret};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [13:0] got;
      e = q.pop_front();
      got = {state, imem_req, ir_we, dmem_req, dmem_we, regfile_we, csr_en, pc_we, pc_sel, trap, retire};
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL %s got=%b expected=%b", e.nm, got, e.v);
      end
    end
  end

  task automatic cyc(input logic r, il, bt, ir, dr, input logic [13:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; illegal = il; branch_taken = bt; imem_ready = ir; dmem_ready = dr;
    x.v = e; x.nm = nm;
    q.push_back(x);
  endtask

  // Stray dmem_ready while fetching must be ignored.
  task automatic fetch(input int nwait);
    for (int i = 0; i < nwait; i++) cyc(0, 0, 0, 0, 1, E(0,1,0,0,0,0,0,0,0,0,0), "fetch_wait");
    cyc(0, 0, 0, 1, 0, E(0,1,1,0,0,0,0,0,0,0,0), "fetch_ready");
  endtask

  // Stray imem_ready in DECODE must not load the IR.
  task automatic decode(input opcode_t o, input logic il);
    op = o;
    cyc(0, il, 0, 1, 0, E(1,0,0,0,0,0,0,0,0,0,0), "decode");
  endtask

  task automatic exec_quiet(input string nm);
    cyc(0, 0, 0, 0, 0, E(2,0,0,0,0,0,0,0,0,0,0), nm);
  endtask

  initial begin
    cyc(1, 0, 0, 1, 1, E(0,0,0,0,0,0,0,0,0,0,0), "reset0");
    cyc(1, 0, 0, 1, 1, E(0,0,0,0,0,0,0,0,0,0,0), "reset1");

    // ALU, zero wait: retire in cycle 4
    fetch(0); decode(reg_arith_type, 0); exec_quiet("alu_exec");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,0,1,0,0,1), "alu_wb");

    // Load, imem 2 late, dmem 3 cycles of request
    fetch(2); decode(load_type, 0); exec_quiet("ld_exec");
    cyc(0, 0, 0, 0, 0, E(3,0,0,1,0,0,0,0,0,0,0), "ld_mem_wait1");
    cyc(0, 0, 0, 0, 0, E(3,0,0,1,0,0,0,0,0,0,0), "ld_mem_wait2");
    cyc(0, 0, 0, 0, 1, E(3,0,0,1,0,0,0,0,0,0,0), "ld_mem_ready");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,0,1,0,0,1), "ld_wb");

    // Store, one wait cycle
    fetch(0); decode(store_type, 0); exec_quiet("st_exec");
    cyc(0, 0, 0, 0, 0, E(3,0,0,1,1,0,0,0,0,0,0), "st_mem_wait");
    cyc(0, 0, 0, 0, 1, E(3,0,0,1,1,0,0,1,0,0,1), "st_mem_ready");

    // Branch taken then not taken
    fetch(0); decode(branch_type, 0);
    cyc(0, 0, 1, 0, 0, E(2,0,0,0,0,0,0,1,1,0,1), "br_taken");
    fetch(1); decode(branch_type, 0);
    cyc(0, 0, 0, 0, 0, E(2,0,0,0,0,0,0,1,0,0,1), "br_not_taken");

    // Fence no-op
    fetch(0); decode(fence_type, 0);
    cyc(0, 0, 1, 0, 0, E(2,0,0,0,0,0,0,1,0,0,1), "fence_exec");

    // Jumps, system and LUI writeback selects
    fetch(0); decode(jalr, 0); exec_quiet("jalr_exec");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,0,1,2,0,1), "jalr_wb");
    fetch(0); decode(jal, 0); exec_quiet("jal_exec");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,0,1,1,0,1), "jal_wb");
    fetch(0); decode(system_type, 0); exec_quiet("sys_exec");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,1,1,0,0,1), "sys_wb");
    fetch(0); decode(lui, 0); exec_quiet("lui_exec");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,0,1,0,0,1), "lui_wb");

    // Illegal instruction
    fetch(0); decode(load_type, 1);
`ifdef KAKACPU_ILLEGAL_TRAP_EN
    cyc(0, 0, 0, 0, 1, E(5,0,0,0,0,0,0,1,3,1,0), "illegal_trap");
`else
    cyc(0, 0, 0, 0, 1, E(2,0,0,0,0,0,0,1,0,0,1), "illegal_noop");
`endif

    // Reset during store MEMORY with dmem_ready high
    fetch(0); decode(store_type, 0); exec_quiet("rst_st_exec");
    cyc(1, 0, 0, 0, 1, E(0,0,0,0,0,0,0,0,0,0,0), "rst_in_mem");
    cyc(0, 0, 0, 0, 0, E(0,1,0,0,0,0,0,0,0,0,0), "rst_release_fetch");
    cyc(0, 0, 0, 1, 0, E(0,1,1,0,0,0,0,0,0,0,0), "rst_refetch");
    decode(imm_arith_type, 0); exec_quiet("post_rst_exec");
    cyc(0, 0, 0, 0, 0, E(4,0,0,0,0,1,0,1,0,0,1), "post_rst_wb");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
